outputc_nvc: RTL and testbench

Parametrised output-channel stage of the router: one instance per physical output port, sitting between the crossbar/switch allocator and the link to the downstream router. It registers the switched flit onto the link and keeps, per virtual channel, a credit count of the downstream input buffer, a ready flag for the VC allocator, a packet lock and a sticky credit-error flag. It generalises the fixed single-VC output channel to NVCH virtual channels with configurable width, buffer depth and packet length, adds tail-flit-aware lock release, and adds saturating credit arithmetic with error reporting.

---
 rtl/outputc_nvc_if.sv | 36 +++
 rtl/outputc_nvc.sv | 130 +++++++++++++
 tb/tb_outputc_nvc.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/outputc_nvc_if.sv
// outputc_nvc_if: flit and flow-control bundle between the switch/allocator
// side (master) and one output-channel stage (slave).
//   idata/ivalid/ivch : switched flit into the stage
//   odata/ovalid/ovch : registered flit towards the link
//   iack              : per-VC credit return from downstream
//   ordy              : per-VC room for a full packet downstream
//   ilck              : per-VC lock held by downstream
//   olck              : per-VC lock of this output
//   oerr              : per-VC sticky credit error
interface outputc_nvc_if #(
  parameter int DATAW = 34,
  parameter int VCHW  = 2,
  parameter int NVCH  = 4
);
  logic [DATAW-1:0] idata;
  logic             ivalid;
  logic [VCHW-1:0]  ivch;
  logic [DATAW-1:0] odata;
  logic             ovalid;
  logic [VCHW-1:0]  ovch;
  logic [NVCH-1:0]  iack;
  logic [NVCH-1:0]  ordy;
  logic [NVCH-1:0]  ilck;
  logic [NVCH-1:0]  olck;
  logic [NVCH-1:0]  oerr;

  modport master (
    output idata, ivalid, ivch, iack, ilck,
    input  odata, ovalid, ovch, ordy, olck, oerr
  );

  modport slave (
    input  idata, ivalid, ivch, iack, ilck,
    output odata, ovalid, ovch, ordy, olck, oerr
  );
endinterface

// File: rtl/outputc_nvc.sv
// outputc_nvc: output-channel stage of a router port with NVCH virtual
// channels. Registers the switched flit onto the link and tracks, per VC,
// downstream credits (saturating, with sticky error), a packet-room ready
// flag and a packet lock released after the tail has left the register.
// Ports:
//   clk  : clock, all state on rising edge
//   rst_ : synchronous active-high reset
//   bus  : outputc_nvc_if slave modport (flit in/out, credits, locks, errors)
module outputc_nvc #(
  parameter int ROUTERID = 0,
  parameter int PCHID    = 0,
  parameter int NVCH     = 4,
  parameter int VCHW     = 2,
  parameter int DATAW    = 34,
  parameter int FIFOD    = 8,
  parameter int PKTLEN   = 4,
  parameter int CNTW     = 4
) (
  input  logic            clk,
  input  logic            rst_,
  outputc_nvc_if.slave    bus
);

  // Identifiers are debug-only; they take part only in this elaboration check.
  if (ROUTERID < 0 || PCHID < 0 || NVCH < 1 || NVCH > 16 || VCHW < 1 ||
      FIFOD < PKTLEN || DATAW < 3) begin : g_bad_params
    $error("outputc_nvc: illegal parameter set");
  end

  logic [DATAW-1:0]           odata_q, odata_d;
  logic                       ovalid_q, ovalid_d;
  logic [VCHW-1:0]            ovch_q, ovch_d;
  logic [NVCH-1:0][CNTW-1:0]  cnt_q, cnt_d;
  logic [NVCH-1:0]            olck_q, olck_d;
  logic [NVCH-1:0]            tailsent_q, tailsent_d;
  logic [NVCH-1:0]            oerr_q, oerr_d;
  logic [NVCH-1:0]            send;
  logic [NVCH-1:0]            ordy;
  logic                       is_tail;

  assign is_tail = (bus.idata[DATAW-1 -: 2] == 2'b11);

  // An out-of-range ivch matches no VC, so the flit is forwarded without
  // touching any counter or lock.
  always_comb begin
    send = '0;
    for (int unsigned v = 0; v < NVCH; v++) begin
      send[v] = bus.ivalid && (bus.ivch == VCHW'(v));
    end
  end

  // Room for a whole packet; one extra bit keeps the subtraction from wrapping.
  always_comb begin
    ordy = '0;
    for (int unsigned v = 0; v < NVCH; v++) begin
      ordy[v] = ({1'b0, CNTW'(FIFOD)} - {1'b0, cnt_q[v]}) >= (CNTW+1)'(PKTLEN);
    end
  end

  always_comb begin
    odata_d  = odata_q;
    ovalid_d = ovalid_q;
    ovch_d   = ovch_q;
    if (bus.ivalid) begin
      odata_d  = bus.idata;
      ovalid_d = 1'b1;
      ovch_d   = bus.ivch;
    end else if (ovalid_q) begin
      odata_d  = '0;
      ovalid_d = 1'b0;
      ovch_d   = '0;
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    oerr_d     = oerr_q;
    olck_d     = olck_q;
    tailsent_d = tailsent_q;
    for (int unsigned v = 0; v < NVCH; v++) begin
      // Saturate at both ends; a saturated step latches the error flag.
      if (send[v] && !bus.iack[v]) begin
        if (cnt_q[v] == CNTW'(FIFOD)) oerr_d[v] = 1'b1;
        else                          cnt_d[v]  = cnt_q[v] + 1'b1;
      end else if (bus.iack[v] && !send[v]) begin
        if (cnt_q[v] == '0) oerr_d[v] = 1'b1;
        else                cnt_d[v]  = cnt_q[v] - 1'b1;
      end

      // Release waits until the tail has left the output register and
      // downstream no longer holds the lock.
      if (send[v]) begin
        olck_d[v]     = 1'b1;
        tailsent_d[v] = is_tail;
      end else if (olck_q[v] && tailsent_q[v] &&
                   !(ovalid_q && (ovch_q == VCHW'(v))) && !bus.ilck[v]) begin
        olck_d[v]     = 1'b0;
        tailsent_d[v] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      odata_q    <= '0;
      ovalid_q   <= 1'b0;
      ovch_q     <= '0;
      cnt_q      <= '0;
      olck_q     <= '0;
      tailsent_q <= '0;
      oerr_q     <= '0;
    end else begin
      odata_q    <= odata_d;
      ovalid_q   <= ovalid_d;
      ovch_q     <= ovch_d;
      cnt_q      <= cnt_d;
      olck_q     <= olck_d;
      tailsent_q <= tailsent_d;
      oerr_q     <= oerr_d;
    end
  end

  assign bus.odata  = odata_q;
  assign bus.ovalid = ovalid_q;
  assign bus.ovch   = ovch_q;
  assign bus.ordy   = ordy;
  assign bus.olck   = olck_q;
  assign bus.oerr   = oerr_q;

endmodule

// File: tb/tb_outputc_nvc.sv
// tb_outputc_nvc: directed bench for outputc_nvc. Forwarded flits are
// checked by a scoreboard queue popped by a negedge monitor; credit, ready,
// lock and error state is checked against hand-computed constants.
module tb_outputc_nvc;
  localparam int NVCH = 4, VCHW = 2, DATAW = 34, FIFOD = 8, PKTLEN = 4, CNTW = 4;
  localparam logic [1:0] T_HEAD = 2'b01, T_BODY = 2'b10, T_TAIL = 2'b11;

  logic clk = 1'b0;
  logic rst_ = 1'b1;
  always #5 clk = ~clk;

  outputc_nvc_if #(.DATAW(DATAW), .VCHW(VCHW), .NVCH(NVCH)) bus ();

  outputc_nvc #(
    .ROUTERID(0), .PCHID(0), .NVCH(NVCH), .VCHW(VCHW), .DATAW(DATAW),
    .FIFOD(FIFOD), .PKTLEN(PKTLEN), .CNTW(CNTW)
  ) dut (
    .clk (clk),
    .rst_(rst_),
    .bus (bus)
  );

  typedef struct packed {
    logic [DATAW-1:0] data;
    logic [VCHW-1:0]  vch;
  } flit_t;

  flit_t exp_q[$];
  int n_vec = 0;
  int n_fail = 0;
  int seq = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; state reflects these inputs when the task returns.
  task automatic drive(input logic v, input logic [VCHW-1:0] ch, input logic [1:0] typ,
                       input logic [NVCH-1:0] ack, input logic [NVCH-1:0] lck);
    logic [DATAW-1:0] d;
    d = v ? {typ, 32'hC0DE_0000 + 32'(seq)} : '0;
    seq++;
    bus.ivalid = v;
    bus.ivch   = ch;
    bus.idata  = d;
    bus.iack   = ack;
    bus.ilck   = lck;
    if (v && !rst_) exp_q.push_back('{data: d, vch: ch});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [NVCH-1:0] ack, input logic [NVCH-1:0] lck);
    drive(1'b0, '0, 2'b00, ack, lck);
  endtask

  task automatic do_reset();
    rst_ = 1'b1;
    drive(1'b1, 2'd2, T_HEAD, 4'b1111, '0);
    drive(1'b1, 2'd1, T_TAIL, 4'b0000, '0);
    exp_q.delete();
    rst_ = 1'b0;
  endtask

  // Monitor: every presented flit must match the oldest expected one.
  always @(negedge clk) begin
    if (bus.ovalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL flit_unexpected: got data %0h vch %0d, expected none", bus.odata, bus.ovch);
      end else begin
        flit_t e;
        e = exp_q.pop_front();
        chk("flit_data", 64'(bus.odata), 64'(e.data));
        chk("flit_vch", 64'(bus.ovch), 64'(e.vch));
      end
    end
  end

  initial begin
    // Reset with ivalid high: everything zero, ready on all VCs.
    do_reset();
    chk("rst_odata", 64'(bus.odata), 64'h0);
    chk("rst_ovalid", 64'(bus.ovalid), 64'h0);
    chk("rst_ovch", 64'(bus.ovch), 64'h0);
    chk("rst_olck", 64'(bus.olck), 64'h0);
    chk("rst_oerr", 64'(bus.oerr), 64'h0);
    chk("rst_ordy", 64'(bus.ordy), 64'hf);
    chk("rst_cnt", 64'(dut.cnt_q), 64'h0);
    idle('0, '0);

    // Credit fill on VC2.
    drive(1'b1, 2'd2, T_HEAD, '0, '0);
    for (int i = 0; i < 3; i++) drive(1'b1, 2'd2, T_BODY, '0, '0);
    chk("fill4_ordy", 64'(bus.ordy), 64'hf);
    drive(1'b1, 2'd2, T_BODY, '0, '0);
    chk("fill5_cnt2", 64'(dut.cnt_q[2]), 64'd5);
    chk("fill5_ordy", 64'(bus.ordy), 64'b1011);
    idle(4'b0100, '0);
    chk("ack_cnt2", 64'(dut.cnt_q[2]), 64'd4);
    chk("ack_ordy", 64'(bus.ordy), 64'hf);

    // Send and credit return together on VC1 leave the count alone.
    for (int i = 0; i < 3; i++) drive(1'b1, 2'd1, T_BODY, '0, '0);
    chk("vc1_cnt3", 64'(dut.cnt_q[1]), 64'd3);
    for (int i = 0; i < 4; i++) drive(1'b1, 2'd1, T_BODY, 4'b0010, '0);
    chk("both_cnt1", 64'(dut.cnt_q[1]), 64'd3);
    chk("both_oerr", 64'(bus.oerr), 64'h0);
    idle('0, '0);

    // Overflow on VC0.
    do_reset();
    for (int i = 0; i < 8; i++) drive(1'b1, 2'd0, T_BODY, '0, '0);
    chk("full_cnt0", 64'(dut.cnt_q[0]), 64'd8);
    chk("full_oerr", 64'(bus.oerr), 64'h0);
    chk("full_ordy", 64'(bus.ordy), 64'b1110);
    drive(1'b1, 2'd0, T_BODY, '0, '0);
    chk("ovf_cnt0", 64'(dut.cnt_q[0]), 64'd8);
    chk("ovf_oerr", 64'(bus.oerr), 64'b0001);
    idle('0, '0);

    // Underflow on VC3.
    do_reset();
    chk("rst_oerr_clr", 64'(bus.oerr), 64'h0);
    idle(4'b1000, '0);
    chk("udf_cnt3", 64'(dut.cnt_q[3]), 64'd0);
    chk("udf_oerr", 64'(bus.oerr), 64'b1000);

    // Lock on VC1 held by downstream, then released.
    do_reset();
    drive(1'b1, 2'd1, T_HEAD, '0, 4'b0010);
    chk("lck_head", 64'(bus.olck), 64'b0010);
    drive(1'b1, 2'd1, T_BODY, '0, 4'b0010);
    drive(1'b1, 2'd1, T_TAIL, '0, 4'b0010);
    for (int i = 0; i < 3; i++) idle('0, 4'b0010);
    chk("lck_held", 64'(bus.olck), 64'b0010);
    idle('0, '0);
    chk("lck_release", 64'(bus.olck), 64'b0000);

    // Single-flit packet on VC2: lock high for exactly two cycles.
    drive(1'b1, 2'd2, T_TAIL, '0, '0);
    chk("single_c1", 64'(bus.olck[2]), 64'd1);
    idle('0, '0);
    chk("single_c2", 64'(bus.olck[2]), 64'd1);
    idle('0, '0);
    chk("single_c3", 64'(bus.olck[2]), 64'd0);

    // Back-to-back interleave of VC0 and VC3.
    do_reset();
    idle('0, '0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, (i % 2 == 0) ? 2'd0 : 2'd3, T_BODY, '0, '0);
      chk("ilv_ovalid", 64'(bus.ovalid), 64'd1);
    end
    chk("ilv_cnt0", 64'(dut.cnt_q[0]), 64'd4);
    chk("ilv_cnt3", 64'(dut.cnt_q[3]), 64'd4);
    chk("ilv_ordy", 64'(bus.ordy), 64'hf);
    idle('0, '0);
    chk("ilv_ovalid_off", 64'(bus.ovalid), 64'd0);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) idle('0, '0);
    idle('0, '0);
    chk("drain", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
